srio_target_responder: RTL
==========================

Name: srio_target_responder

Overview:
- SRIO logical-layer target: consumes HELLO-format target requests (treq AXI-Stream) from the srio_gen2 core.
- Executes them against a local 64-bit-wide register memory.
- Returns HELLO-format responses on the tresp AXI-Stream.
- Acts as the far-end counterpart to the initiator ireq/iresp path; lives in the log_clk domain beside the SRIO example top.

Parameters:
- MEM_DEPTH, 64: number of 64-bit words in local memory; power of two, 2..1024.
- BASE_ADDR, 34'h0: byte address of word 0; requests outside [BASE_ADDR, BASE_ADDR+8*MEM_DEPTH) are errors.

Ports:
- log_clk  in  1  logical-layer clock; all logic on its rising edge.
- log_rst  in  1  reset, asynchronous assert, active-high.
- axis_treq_tvalid  in  1  request beat valid.
- axis_treq_tready  out  1  request beat accepted.
- axis_treq_tlast  in  1  last beat of request packet.
- axis_treq_tdata  in  64  header (beat 0) / payload.
- axis_treq_tkeep  in  8  byte enables for payload beats.
- axis_treq_tuser  in  32  [31:16] src ID, [15:0] dest ID; sampled on header beat.
- axis_tresp_tvalid  out  1  response beat valid.
- axis_tresp_tready  in  1  downstream ready.
- axis_tresp_tlast  out  1  last beat of response.
- axis_tresp_tdata  out  64  response header / read data.
- axis_tresp_tkeep  out  8  always 8'hFF.
- axis_tresp_tuser  out  32  {req dest ID, req src ID} (IDs swapped).

Behaviour:
- Header fields: tid[63:56], ftype[55:52], ttype[51:48], prio[46:45], crf[44], size[43:36] = bytes-1, addr[33:0].
- Supported requests:
  - NREAD: ftype 2, ttype 4.
  - NWRITE: ftype 5, ttype 4; no response.
  - NWRITE_R: ftype 5, ttype 5.
- Beat count N = size[7:3]+1.
- A request is legal only if all hold: addr[2:0]=0, size[2:0]=3'b111, whole range inside memory.
- Response header: tid echoed; ftype 13; ttype 8 for read-with-data, 0 otherwise; prio = min(req prio+1,3); crf echoed; bit[35] = error; all other bits 0.
- States: IDLE, WR_DATA, DRAIN, RESP_HDR, RD_DATA.
- IDLE:
  - treq_tready=1; header handshake latches tid/prio/crf/IDs/addr/N.
  - NREAD legal -> RESP_HDR (data follows).
  - NWRITE/NWRITE_R legal -> WR_DATA.
  - Any illegal or unsupported request -> DRAIN if tlast=0, else RESP_HDR with error=1.
- WR_DATA:
  - treq_tready=1; each beat writes its enabled bytes to mem[(addr-BASE_ADDR)>>3 + k].
  - The beat carrying tlast must be beat N.
  - tlast early, or no tlast by beat N: flag error, stop writing, go to DRAIN unless the current beat is last.
  - On good completion: NWRITE -> IDLE; NWRITE_R -> RESP_HDR (error=0).
- DRAIN: treq_tready=1, discard beats until tlast, then RESP_HDR with error=1.
- RESP_HDR: treq_tready=0; tresp_tvalid=1.
  - tlast=1 when ttype 0; tlast=0 for read data.
  - On handshake: read -> RD_DATA, else -> IDLE.
- RD_DATA:
  - Beats k=0..N-1 read combinationally from memory, back-to-back while tresp_tready=1.
  - tlast on beat N-1; on its handshake -> IDLE.
- Latency: response header valid the cycle after the request's final handshake (header beat for NREAD).
- Output rules:
  - All tresp outputs registered.
  - tvalid/tdata/tlast hold stable while tvalid=1 and tready=0.
- Errors: an NWRITE (no-response) error is silently dropped after draining.
- Reset:
  - log_rst asserted at any time forces IDLE, tresp_tvalid=0, tlast=0, tdata=0, tuser=0, treq_tready=0 while in reset; tkeep reads 8'hFF.
  - Memory contents are not reset; an in-flight packet is abandoned.
- treq_tready goes to 1 the first cycle after reset deasserts.

Optional Feature:
- Macro: SRIO_TARGET_STATS_EN.
- When defined, three extra outputs are added: stat_rd_cnt[15:0], stat_wr_cnt[15:0], stat_err_cnt[15:0].
  - stat_rd_cnt counts completed NREADs; stat_wr_cnt counts completed good writes; stat_err_cnt counts error-flagged requests.
  - Each counter saturates at 16'hFFFF and resets to 0.
- When undefined, these ports and their logic are absent and behaviour is otherwise identical.

Test Plan:
- NWRITE_R tid=8'h3C, addr=0x10, size=15, 2 beats A/B, tuser=32'h0001_0002 -> mem[2]=A, mem[3]=B.
  - One response beat follows: ftype 13, ttype 0, tid 8'h3C, bit35=0, tlast=1, tuser=32'h0002_0001.
- NREAD addr=0x10, size=15 after the above -> response header ttype 8, then A, B back-to-back, tlast on B.
  - tresp_tready toggling 1/0 must not drop, duplicate or alter beats.
- NWRITE addr=0x8, size=7, tkeep=8'h0F, data 64'h1111_2222_3333_4444 -> only low 4 bytes of mem[1] updated; no response beat.
- NREAD addr=0x4 (misaligned) -> error response (bit35=1, ttype 0) one cycle after the header.
  - NREAD addr=8*MEM_DEPTH -> same error response.
- NWRITE_R size=23 (3 beats) with tlast on beat 2 -> memory writes beat 1 only; error response issued; next request processes normally.
- Assert log_rst during RD_DATA beat 1 -> tresp_tvalid=0 in the same cycle; after release, a new NREAD returns a correct full response.

Source files
------------

// File: rtl/srio_target_responder.sv
// SRIO logical-layer target: executes HELLO NREAD/NWRITE/NWRITE_R against a local 64-bit memory.
// Optional request/error counters are added when SRIO_TARGET_STATS_EN is defined.
module srio_target_responder #(
    parameter int unsigned MEM_DEPTH = 64,
    parameter logic [33:0] BASE_ADDR = 34'h0
) (
    input  logic        log_clk,
    input  logic        log_rst,
    input  logic        axis_treq_tvalid,
    output logic        axis_treq_tready,
    input  logic        axis_treq_tlast,
    input  logic [63:0] axis_treq_tdata,
    input  logic [7:0]  axis_treq_tkeep,
    input  logic [31:0] axis_treq_tuser,
    output logic        axis_tresp_tvalid,
    input  logic        axis_tresp_tready,
    output logic        axis_tresp_tlast,
    output logic [63:0] axis_tresp_tdata,
    output logic [7:0]  axis_tresp_tkeep,
    output logic [31:0] axis_tresp_tuser
`ifdef SRIO_TARGET_STATS_EN
    ,
    output logic [15:0] stat_rd_cnt,
    output logic [15:0] stat_wr_cnt,
    output logic [15:0] stat_err_cnt
`endif
);

    localparam int unsigned IW = $clog2(MEM_DEPTH);

    typedef enum logic [2:0] {StIdle, StWrData, StDrain, StRespHdr, StRdData} state_e;

    function automatic logic [63:0] mk_hdr(input logic [7:0] tid, input logic [1:0] prio,
                                           input logic crf, input logic data, input logic err);
        logic [1:0] p;
        p = (prio == 2'd3) ? 2'd3 : prio + 2'd1;
        return {tid, 4'd13, (data ? 4'd8 : 4'd0), 1'b0, p, crf, 8'd0, err, 35'd0};
    endfunction

    logic [63:0] mem [MEM_DEPTH];

    state_e          state_q, state_d;
    logic            rdy_q;
    logic [7:0]      tid_q, tid_d;
    logic [1:0]      prio_q, prio_d;
    logic            crf_q, crf_d;
    logic [31:0]     ids_q, ids_d;
    logic [IW-1:0]   base_idx_q, base_idx_d;
    logic [4:0]      nm1_q, nm1_d;
    logic [4:0]      k_q, k_d;
    logic            is_read_q, is_read_d;
    logic            want_resp_q, want_resp_d;
    logic            tvalid_q, tvalid_d;
    logic            tlast_q, tlast_d;
    logic [63:0]     tdata_q, tdata_d;
    logic [31:0]     tuser_q, tuser_d;

    // Header decode
    logic [7:0]  hdr_tid;
    logic [3:0]  hdr_ftype, hdr_ttype;
    logic [1:0]  hdr_prio;
    logic        hdr_crf;
    logic [7:0]  hdr_size;
    logic [35:0] addr36, base36, off36, end_word;
    logic        is_rd, is_nw, is_nwr, legal, hdr_ok;

    assign hdr_tid   = axis_treq_tdata[63:56];
    assign hdr_ftype = axis_treq_tdata[55:52];
    assign hdr_ttype = axis_treq_tdata[51:48];
    assign hdr_prio  = axis_treq_tdata[46:45];
    assign hdr_crf   = axis_treq_tdata[44];
    assign hdr_size  = axis_treq_tdata[43:36];
    assign addr36    = {2'b00, axis_treq_tdata[33:0]};
    assign base36    = {2'b00, BASE_ADDR};
    assign off36     = addr36 - base36;
    assign end_word  = {3'b000, off36[35:3]} + {31'd0, hdr_size[7:3]} + 36'd1;

    assign is_rd  = (hdr_ftype == 4'd2) && (hdr_ttype == 4'd4);
    assign is_nw  = (hdr_ftype == 4'd5) && (hdr_ttype == 4'd4);
    assign is_nwr = (hdr_ftype == 4'd5) && (hdr_ttype == 4'd5);
    assign legal  = (addr36[2:0] == 3'd0) && (hdr_size[2:0] == 3'b111) &&
                    (addr36 >= base36) && (end_word <= 36'(MEM_DEPTH));
    // A read header must end its packet; a write header must be followed by payload
    assign hdr_ok = legal && ((is_rd && axis_treq_tlast) || ((is_nw || is_nwr) && !axis_treq_tlast));

    logic          hs_in, hs_out, at_last;
    logic [4:0]    rd_k;
    logic [IW-1:0] rd_idx, wr_idx;
    logic          mem_we;
    logic          load_hdr, load_err;

    assign axis_treq_tready = rdy_q &&
        (state_q == StIdle || state_q == StWrData || state_q == StDrain);
    assign hs_in   = axis_treq_tvalid && axis_treq_tready;
    assign hs_out  = tvalid_q && axis_tresp_tready;
    assign at_last = (k_q == nm1_q);
    assign rd_k    = (state_q == StRdData) ? k_q + 5'd1 : 5'd0;
    assign rd_idx  = base_idx_q + IW'(rd_k);
    assign wr_idx  = base_idx_q + IW'(k_q);

    always_comb begin
        state_d     = state_q;
        tid_d       = tid_q;
        prio_d      = prio_q;
        crf_d       = crf_q;
        ids_d       = ids_q;
        base_idx_d  = base_idx_q;
        nm1_d       = nm1_q;
        k_d         = k_q;
        is_read_d   = is_read_q;
        want_resp_d = want_resp_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        tdata_d     = tdata_q;
        tuser_d     = tuser_q;
        mem_we      = 1'b0;
        load_hdr    = 1'b0;
        load_err    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (hs_in) begin
                    tid_d       = hdr_tid;
                    prio_d      = hdr_prio;
                    crf_d       = hdr_crf;
                    ids_d       = axis_treq_tuser;
                    base_idx_d  = off36[IW+2:3];
                    nm1_d       = hdr_size[7:3];
                    k_d         = 5'd0;
                    is_read_d   = is_rd;
                    want_resp_d = !is_nw;
                    if (hdr_ok && is_rd) begin
                        load_hdr = 1'b1;
                    end else if (hdr_ok) begin
                        state_d = StWrData;
                    end else if (!axis_treq_tlast) begin
                        state_d = StDrain;
                    end else if (!is_nw) begin
                        load_hdr = 1'b1;
                        load_err = 1'b1;
                    end
                end
            end
            StWrData: begin
                if (hs_in) begin
                    if (axis_treq_tlast == at_last) begin
                        if (at_last) begin
                            mem_we = 1'b1;
                            if (want_resp_q) load_hdr = 1'b1;
                            else             state_d = StIdle;
                        end else begin
                            mem_we = 1'b1;
                            k_d    = k_q + 5'd1;
                        end
                    end else if (!axis_treq_tlast) begin
                        state_d = StDrain;
                    end else if (want_resp_q) begin
                        load_hdr = 1'b1;
                        load_err = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StDrain: begin
                if (hs_in && axis_treq_tlast) begin
                    if (want_resp_q) begin
                        load_hdr = 1'b1;
                        load_err = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StRespHdr: begin
                if (hs_out) begin
                    if (tlast_q) begin
                        state_d  = StIdle;
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                    end else begin
                        state_d = StRdData;
                        k_d     = 5'd0;
                        tdata_d = mem[rd_idx];
                        tlast_d = (nm1_q == 5'd0);
                    end
                end
            end
            StRdData: begin
                if (hs_out) begin
                    if (tlast_q) begin
                        state_d  = StIdle;
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                    end else begin
                        k_d     = k_q + 5'd1;
                        tdata_d = mem[rd_idx];
                        tlast_d = ((k_q + 5'd1) == nm1_q);
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (load_hdr) begin
            state_d  = StRespHdr;
            tvalid_d = 1'b1;
            tlast_d  = !(is_read_d && !load_err);
            tdata_d  = mk_hdr(tid_d, prio_d, crf_d, is_read_d && !load_err, load_err);
            tuser_d  = {ids_d[15:0], ids_d[31:16]};
        end
    end

    always_ff @(posedge log_clk or posedge log_rst) begin
        if (log_rst) begin
            state_q     <= StIdle;
            rdy_q       <= 1'b0;
            tid_q       <= '0;
            prio_q      <= '0;
            crf_q       <= 1'b0;
            ids_q       <= '0;
            base_idx_q  <= '0;
            nm1_q       <= '0;
            k_q         <= '0;
            is_read_q   <= 1'b0;
            want_resp_q <= 1'b0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tdata_q     <= '0;
            tuser_q     <= '0;
        end else begin
            state_q     <= state_d;
            rdy_q       <= 1'b1;
            tid_q       <= tid_d;
            prio_q      <= prio_d;
            crf_q       <= crf_d;
            ids_q       <= ids_d;
            base_idx_q  <= base_idx_d;
            nm1_q       <= nm1_d;
            k_q         <= k_d;
            is_read_q   <= is_read_d;
            want_resp_q <= want_resp_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            tdata_q     <= tdata_d;
            tuser_q     <= tuser_d;
        end
    end

    // Memory contents deliberately survive reset
    always_ff @(posedge log_clk) begin
        if (mem_we) begin
            for (int i = 0; i < 8; i++) begin
                if (axis_treq_tkeep[i]) mem[wr_idx][8*i +: 8] <= axis_treq_tdata[8*i +: 8];
            end
        end
    end

    assign axis_tresp_tvalid = tvalid_q;
    assign axis_tresp_tlast  = tlast_q;
    assign axis_tresp_tdata  = tdata_q;
    assign axis_tresp_tkeep  = 8'hFF;
    assign axis_tresp_tuser  = tuser_q;

`ifdef SRIO_TARGET_STATS_EN
    logic        rd_inc, wr_inc, err_inc;
    logic [15:0] rd_cnt_q, wr_cnt_q, err_cnt_q;

    assign rd_inc  = (state_q == StRdData) && hs_out && tlast_q;
    assign wr_inc  = (state_q == StWrData) && hs_in && axis_treq_tlast && at_last;
    assign err_inc = ((state_q == StIdle) && hs_in && !hdr_ok) ||
                     ((state_q == StWrData) && hs_in && (axis_treq_tlast != at_last));

    always_ff @(posedge log_clk or posedge log_rst) begin
        if (log_rst) begin
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            if (rd_inc && rd_cnt_q != 16'hFFFF)   rd_cnt_q  <= rd_cnt_q + 16'd1;
            if (wr_inc && wr_cnt_q != 16'hFFFF)   wr_cnt_q  <= wr_cnt_q + 16'd1;
            if (err_inc && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign stat_rd_cnt  = rd_cnt_q;
    assign stat_wr_cnt  = wr_cnt_q;
    assign stat_err_cnt = err_cnt_q;
`endif

endmodule
